// File: rtl/conv_mac_layer_pkg.sv
// Shared types and the output activation helper for the conv/dense MAC layer.
package conv_mac_layer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    MAC   = 2'd2,
    WRITE = 2'd3
  } state_t;

  // ReLU, then arithmetic right shift by frac, then clamp to an unsigned dw-bit word.
  function automatic logic [63:0] relu_shift_sat(input logic signed [63:0] y,
                                                 input int frac,
                                                 input int dw);
    logic [63:0] t;
    logic [63:0] lim;
    lim = (64'd1 << dw) - 64'd1;
    if (y < 0) begin
      t = 64'd0;
    end else begin
      t = y >> frac;
    end
    return (t > lim) ? lim : t;
  endfunction

endpackage

// File: rtl/conv_mac_layer_if.sv
// Bus bundle of the MAC layer: start handshake, weight ROM port, output buffer read port.
// Handshake: a vector is accepted on a clock edge where strt && rdy; din must then stay stable
// until done. A pop happens on an edge where rd && count != 0, and rd_vld/dout follow one cycle later.
interface conv_mac_layer_if #(
  parameter int DW    = 18,
  parameter int WW    = 9,
  parameter int N_IN  = 18,
  parameter int K     = 3,
  parameter int N_CH  = 4,
  parameter int DEPTH = 64
);
  import conv_mac_layer_pkg::*;

  localparam int NSTEP = N_IN / K;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int AW    = $clog2(DEPTH);

  logic                             strt;
  logic                             rdy;
  logic [N_IN-1:0][DW-1:0]          din;
  logic [SW-1:0]                    w_addr;
  logic [N_CH-1:0][K-1:0][WW-1:0]   w_din;
  logic [N_CH-1:0][WW-1:0]          bias;
  logic                             done;
  logic                             rd;
  logic                             rd_vld;
  logic [N_CH-1:0][DW-1:0]          dout;
  logic [AW:0]                      count;
  logic                             clr;
  state_t                           dbg_state;

  modport master (
    output strt, din, w_din, bias, rd, clr,
    input  rdy, w_addr, done, rd_vld, dout, count, dbg_state
  );

  modport slave (
    input  strt, din, w_din, bias, rd, clr,
    output rdy, w_addr, done, rd_vld, dout, count, dbg_state
  );

endinterface

// File: rtl/conv_mac_layer_lane.sv
// One output channel: K signed multipliers, adder tree, accumulator and bias/ReLU/shift/saturate.
module conv_mac_lane
  import conv_mac_layer_pkg::*;
#(
  parameter int DW   = 18,
  parameter int WW   = 9,
  parameter int N_IN = 18,
  parameter int K    = 3,
  parameter int FRAC = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [K-1:0][DW-1:0]    x_i,
  input  logic [K-1:0][WW-1:0]    w_i,
  input  logic [WW-1:0]           bias_i,
  output logic [DW-1:0]           y_o
);

  localparam int PW   = DW + WW;
  localparam int ACCW = DW + WW + $clog2(N_IN) + 1;

  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] y;

  // Products are formed at full DW+WW precision before widening into the accumulator.
  always_comb begin
    sum = '0;
    for (int t = 0; t < K; t++) begin
      sum = sum + ACCW'(PW'($signed(x_i[t])) * PW'($signed(w_i[t])));
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (en_i) begin
      acc_d = acc_q + sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign y   = acc_q + ACCW'($signed(bias_i));
  assign y_o = DW'(relu_shift_sat(64'(y), FRAC, DW));

endmodule

// File: rtl/conv_mac_layer.sv
// MAC layer top: sequencing FSM, weight ROM addressing, N_CH lanes and the shared output buffer.
module conv_mac_layer
  import conv_mac_layer_pkg::*;
#(
  parameter int DW    = 18,
  parameter int WW    = 9,
  parameter int N_IN  = 18,
  parameter int K     = 3,
  parameter int N_CH  = 4,
  parameter int DEPTH = 64,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  conv_mac_layer_if.slave  bus
);

  localparam int NSTEP = N_IN / K;
  localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = (N_IN > 1) ? $clog2(N_IN) : 1;

  state_t        state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [SW-1:0] w_addr_q, w_addr_d;

  logic rdy, accept, done, acc_clr, acc_en, push, pop;

  logic [K-1:0][DW-1:0]    x_sel;
  logic [N_CH-1:0][DW-1:0] lane_y;

  logic [N_CH-1:0][DW-1:0] mem [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic [N_CH-1:0][DW-1:0] dout_q, dout_d;
  logic                    rd_vld_q, rd_vld_d;

  function automatic logic [SW-1:0] cap_addr(input int a);
    return (a > NSTEP - 1) ? SW'(NSTEP - 1) : SW'(a);
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      state_q  <= IDLE;
      step_q   <= '0;
      w_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      w_addr_q <= w_addr_d;
    end
  end

  // Next state; w_addr runs one row ahead so the registered ROM output lines up with each step.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    w_addr_d = w_addr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = PRIME;
          step_d   = '0;
          w_addr_d = '0;
        end
      end
      PRIME: begin
        state_d  = MAC;
        w_addr_d = cap_addr(1);
      end
      MAC: begin
        w_addr_d = cap_addr(int'(step_q) + 2);
        if (step_q == SW'(NSTEP - 1)) begin
          state_d = WRITE;
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      WRITE: begin
        state_d  = IDLE;
        w_addr_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rdy     = (state_q == IDLE) && (count_q != (AW+1)'(DEPTH));
    accept  = bus.strt && rdy && !bus.clr;
    done    = (state_q == WRITE) && !bus.clr;
    acc_clr = bus.clr || accept;
    acc_en  = (state_q == MAC);
  end

  always_comb begin
    x_sel = '0;
    for (int t = 0; t < K; t++) begin
      x_sel[t] = bus.din[IW'(int'(step_q) * K + t)];
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    conv_mac_lane #(
      .DW   (DW),
      .WW   (WW),
      .N_IN (N_IN),
      .K    (K),
      .FRAC (FRAC)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (acc_clr),
      .en_i   (acc_en),
      .x_i    (x_sel),
      .w_i    (bus.w_din[c]),
      .bias_i (bus.bias[c]),
      .y_o    (lane_y[c])
    );
  end

  // A write only happens after an accept, which requires a non-full buffer, so push never overflows.
  assign push = done;
  assign pop  = bus.rd && (count_q != '0) && !bus.clr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    rd_vld_d = pop;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      dout_d   = mem[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= lane_y;
    end
  end

  assign bus.rdy       = rdy;
  assign bus.done      = done;
  assign bus.w_addr    = w_addr_q;
  assign bus.rd_vld    = rd_vld_q;
  assign bus.dout      = dout_q;
  assign bus.count     = count_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_conv_mac_layer.sv
// Bench for conv_mac_layer: table vectors, random vectors against an arithmetic model, buffer and abort corners.
module tb_conv_mac_layer;
  import conv_mac_layer_pkg::*;

  localparam int DW    = 18;
  localparam int WW    = 9;
  localparam int N_IN  = 18;
  localparam int K     = 3;
  localparam int N_CH  = 4;
  localparam int DEPTH = 64;
  localparam int FRAC  = 8;
  localparam int NSTEP = N_IN / K;
  localparam int OW    = N_CH * DW;

  logic clk;
  logic rst_n;

  conv_mac_layer_if #(.DW(DW), .WW(WW), .N_IN(N_IN), .K(K), .N_CH(N_CH), .DEPTH(DEPTH)) bus ();

  conv_mac_layer #(
    .DW(DW), .WW(WW), .N_IN(N_IN), .K(K), .N_CH(N_CH), .DEPTH(DEPTH), .FRAC(FRAC)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // External weight ROM with one cycle of read latency
  logic [WW-1:0] wrom [NSTEP][N_CH][K];
  always @(posedge clk) begin
    for (int c = 0; c < N_CH; c++)
      for (int t = 0; t < K; t++)
        bus.w_din[c][t] <= wrom[int'(bus.w_addr)][c][t];
  end

  // Scoreboard
  int errors = 0;
  int checks = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] last_pop;

  typedef struct {
    int din;
    int w   [N_CH];
    int b   [N_CH];
    int res [N_CH];
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Dot product over the whole vector, bias, ReLU, shift, clamp.
  function automatic logic [OW-1:0] model();
    logic [OW-1:0] r;
    longint acc;
    longint lim;
    r   = '0;
    lim = (longint'(1) << DW) - 1;
    for (int c = 0; c < N_CH; c++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++)
        acc += longint'($signed(bus.din[i])) * longint'($signed(wrom[i / K][c][i % K]));
      acc += longint'($signed(bus.bias[c]));
      if (acc < 0) acc = 0;
      acc = acc >>> FRAC;
      if (acc > lim) acc = lim;
      r[c*DW +: DW] = DW'(acc);
    end
    return r;
  endfunction

  // Driver tasks (all driving happens just after a falling edge)
  task automatic set_uniform(input int k);
    for (int i = 0; i < N_IN; i++) bus.din[i] = DW'(tbl[k].din);
    for (int c = 0; c < N_CH; c++) begin
      bus.bias[c] = WW'(tbl[k].b[c]);
      for (int s = 0; s < NSTEP; s++)
        for (int t = 0; t < K; t++) wrom[s][c][t] = WW'(tbl[k].w[c]);
    end
  endtask

  task automatic rand_vec(input int mode);
    int v;
    for (int i = 0; i < N_IN; i++) begin
      v = (mode == 0) ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
      bus.din[i] = DW'(v);
    end
    for (int c = 0; c < N_CH; c++) begin
      bus.bias[c] = WW'($urandom);
      for (int s = 0; s < NSTEP; s++)
        for (int t = 0; t < K; t++) wrom[s][c][t] = WW'($urandom);
    end
  endtask

  task automatic start_vec();
    bus.strt = 1'b1;
    @(negedge clk);
    bus.strt = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("done_seen", bus.done, 1'b1);
  endtask

  task automatic run_vec(input logic [OW-1:0] expv, input bit chk_lat);
    int cyc;
    start_vec();
    wait_done(cyc);
    if (chk_lat) check("latency", cyc, NSTEP + 2);
    exp_q.push_back(expv);
    @(negedge clk);
    check("done_pulse", bus.done, 1'b0);
  endtask

  task automatic pop_check();
    logic [OW-1:0] e;
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    check("rd_vld", bus.rd_vld, 1'b1);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: got pop with no expected entry, required an expected entry");
    end else begin
      e = exp_q.pop_front();
      check("dout", bus.dout, e);
      last_pop = e;
    end
  endtask

  initial begin
    logic [OW-1:0] e;
    int cyc;
    bit seen;

    tbl[0].din = 256;     tbl[0].w = '{255, 255, 255, 255}; tbl[0].b = '{0, 0, 0, 0};
    tbl[0].res = '{4590, 4590, 4590, 4590};
    tbl[1].din = 256;     tbl[1].w = '{-1, 1, 1, 1};        tbl[1].b = '{0, -5, 0, 0};
    tbl[1].res = '{0, 17, 18, 18};
    tbl[2].din = 131071;  tbl[2].w = '{255, 255, 255, 255}; tbl[2].b = '{0, 0, 0, 0};
    tbl[2].res = '{262143, 262143, 262143, 262143};
    tbl[3].din = -1000;   tbl[3].w = '{-3, 3, 100, -100};   tbl[3].b = '{0, 255, 0, -256};
    tbl[3].res = '{210, 0, 0, 7030};

    rst_n    = 1'b0;
    bus.strt = 1'b0;
    bus.rd   = 1'b0;
    bus.clr  = 1'b0;
    bus.din  = '0;
    bus.bias = '0;
    last_pop = '0;
    for (int s = 0; s < NSTEP; s++)
      for (int c = 0; c < N_CH; c++)
        for (int t = 0; t < K; t++) wrom[s][c][t] = '0;

    repeat (3) @(negedge clk);
    check("rst_rdy", bus.rdy, 1'b1);
    check("rst_done", bus.done, 1'b0);
    check("rst_rd_vld", bus.rd_vld, 1'b0);
    check("rst_dout", bus.dout, '0);
    check("rst_count", bus.count, '0);
    check("rst_w_addr", bus.w_addr, '0);
    check("rst_state", bus.dbg_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors with hand-computed results
    for (int k = 0; k < 4; k++) begin
      set_uniform(k);
      e = '0;
      for (int c = 0; c < N_CH; c++) e[c*DW +: DW] = DW'(tbl[k].res[c]);
      run_vec(e, k == 0);
      pop_check();
    end

    // Fill the buffer with random vectors
    for (int n = 0; n < DEPTH; n++) begin
      rand_vec(n % 2);
      run_vec(model(), 1'b0);
    end
    check("full_count", bus.count, DEPTH);
    check("full_rdy", bus.rdy, 1'b0);

    rand_vec(1);
    start_vec();
    seen = 1'b0;
    repeat (12) begin
      if (bus.done) seen = 1'b1;
      @(negedge clk);
    end
    check("strt_ignored_done", seen, 1'b0);
    check("strt_ignored_count", bus.count, DEPTH);
    pop_check();
    check("after_pop_rdy", bus.rdy, 1'b1);
    check("after_pop_count", bus.count, DEPTH - 1);

    // Simultaneous push and pop at count 10
    while (exp_q.size() > 10) pop_check();
    check("count10", bus.count, 10);
    rand_vec(1);
    e = model();
    start_vec();
    wait_done(cyc);
    exp_q.push_back(e);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    check("pushpop_count", bus.count, 10);
    check("pushpop_rd_vld", bus.rd_vld, 1'b1);
    e = exp_q.pop_front();
    check("pushpop_dout", bus.dout, e);
    last_pop = e;

    while (exp_q.size() > 0) pop_check();
    check("drained_count", bus.count, 0);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    check("empty_rd_vld", bus.rd_vld, 1'b0);
    check("empty_dout_hold", bus.dout, last_pop);

    // Abort during MAC step 3 with data in the buffer
    for (int n = 0; n < 2; n++) begin
      rand_vec(1);
      run_vec(model(), 1'b0);
    end
    rand_vec(1);
    start_vec();
    repeat (4) @(negedge clk);
    check("clr_in_mac", bus.dbg_state, MAC);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    exp_q.delete();
    check("clr_count", bus.count, 0);
    check("clr_rdy", bus.rdy, 1'b1);
    check("clr_rd_vld", bus.rd_vld, 1'b0);
    check("clr_dout", bus.dout, '0);
    check("clr_state", bus.dbg_state, IDLE);
    check("clr_w_addr", bus.w_addr, '0);
    seen = 1'b0;
    repeat (10) begin
      if (bus.done) seen = 1'b1;
      @(negedge clk);
    end
    check("clr_no_done", seen, 1'b0);

    rand_vec(1);
    run_vec(model(), 1'b1);
    rand_vec(0);
    run_vec(model(), 1'b0);
    pop_check();
    pop_check();
    check("final_count", bus.count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
